ps2_decoder: RTL and testbench
==============================

// Module: ps2_decoder
// PURPOSE
//  PS/2 keyboard receiver for the board top. Samples the asynchronous PS/2 clock/data
//  lines in the CLOCK_50 domain and deframes 11-bit device-to-host frames. Tracks the
//  Set-2 make/break (F0) and extended (E0) prefixes, and translates make codes to ASCII.
//  The top reads ascii_code over the bus and raises an interrupt from key_pressed.
// PARAMETERS
//  TIMEOUT_CYCLES  100000  idle clk cycles (2 ms @50 MHz) mid-frame before frame abort
// PORTS
//  clk             in   1  system clock (CLOCK_50), single clock domain
//  reset_n         in   1  asynchronous, active-low reset
//  ps2_clk_async   in   1  raw PS/2 clock, asynchronous to clk
//  ps2_data_async  in   1  raw PS/2 data, asynchronous to clk
//  scan_code       out  8  last accepted non-modifier make code
//  ascii_code      out  8  ASCII of that make code; 0 if unmapped or E0-extended
//  key_pressed     out  1  level: high from make until break of the same code
//  key_released    out  1  one-clk pulse when the break of the held code completes
// BEHAVIOUR
//  - Reset (async assert, sync release):
//    - Outputs: scan_code=0, ascii_code=0, key_pressed=0, key_released=0.
//    - Internal state: bit count=0, flags brk/ext/shift=0, synchronizers=1.
//  - Sync: 2-FF synchronizer on each line, then a 3rd stage for edge detect.
//    - A bit is sampled on the synchronized ps2_clk falling edge (prev=1, now=0).
//  - Frame: start(0), d0..d7 LSB first, odd parity, stop(1).
//    - 4-bit counter 0..10; the byte completes on the stop bit.
//    - Start bit sampled as 1: ignore that edge, counter stays 0.
//    - Parity or stop error: discard the byte; counter returns to 0; no output change.
//  - Timeout: a counter increments while the frame counter != 0; it clears on every falling edge.
//    - Reaching TIMEOUT_CYCLES aborts the frame (counter=0) and clears the brk/ext flags.
//  - Byte handling, one clk after the stop bit:
//    - E0: set ext.
//    - F0: set brk.
//    - 12/59 (L/R shift): shift=~brk. scan_code, ascii_code and key_pressed unchanged.
//    - Other code, brk=0 (make): scan_code<=code; ascii_code<=map(code,shift), 0 if ext;
//      key_pressed<=1. A typematic repeat re-writes the same values; key_pressed stays 1.
//    - Other code, brk=1 (break): if code==scan_code then key_pressed<=0 and pulse
//      key_released for 1 clk. Break of any other key: no output change.
//      scan_code and ascii_code hold their values through the release.
//    - After any non-prefix byte, brk and ext clear.
//  - ASCII map, unshifted/shifted:
//    - Letters: a-z / A-Z.
//      1C a, 32 b, 21 c, 23 d, 24 e, 2B f, 34 g, 33 h, 43 i, 3B j, 42 k, 4B l, 3A m,
//      31 n, 44 o, 4D p, 15 q, 2D r, 1B s, 2C t, 3C u, 2A v, 1D w, 22 x, 35 y, 1A z.
//    - Digits: 45..46 map to 0-9 (45 0, 16 1, 1E 2, 26 3, 25 4, 2E 5, 36 6, 3D 7, 3E 8, 46 9).
//      Shifted digits give )!@#$%^&*( .
//    - Punctuation: 4E -/_, 55 =/+, 54 [/{, 5B ]/}, 5D \/|, 4C ;/:, 52 '/",
//      41 ,/<, 49 ./>, 4A //?, 0E `/~.
//    - Control: 29 ->20, 5A ->0D, 66 ->08, 0D ->09, 76 ->1B. Any other code -> 00.
//  - Simultaneous events: a falling edge and a timeout expiry in the same clk -> the edge wins.
// STRUCTURE
//  - Shared package: Set-2 constants (E0, F0, LSHIFT 12, RSHIFT 59) and TIMEOUT default.
//  - One sub-module, ps2_scan_to_ascii: combinational case table, (code, shift) -> ascii.
//  - Deframing, timeout and prefix/flag logic stay in this module.
// TESTING
//  - Send frame 1C (parity 0) -> scan_code=1C, ascii_code=61, key_pressed=1, key_released=0.
//  - Send F0,1C after the make -> key_pressed=0, key_released high exactly 1 clk,
//    ascii_code still 61.
//  - Send 12, then 1C, then 16 -> ascii 41 then 21. Send F0,12, then 1C -> ascii 61.
//  - Send 1C with a bad parity bit -> no output change; next good frame 32 -> ascii_code=62.
//  - Send 6 bits then stop clocking for >TIMEOUT_CYCLES, then full frame 29
//    -> scan_code=29, ascii_code=20.
//  - Send E0,75 -> scan_code=75, ascii_code=00, key_pressed=1.
//    Assert reset_n=0 mid-frame -> all outputs 0 immediately.

Source files
------------

// File: rtl/ps2_decoder_pkg.sv
`default_nettype none
// =============================================================================
// Module : ps2_decoder_pkg
// Brief  : Shared PS/2 Set-2 constants, scan-code type and frame check helper.
// Rev    : 1.0  initial release
// =============================================================================
package ps2_decoder_pkg;

    typedef logic [7:0] scan_t;

    localparam scan_t      c_code_ext        = 8'hE0;
    localparam scan_t      c_code_brk        = 8'hF0;
    localparam scan_t      c_code_lshift     = 8'h12;
    localparam scan_t      c_code_rshift     = 8'h59;
    localparam int         c_timeout_default = 100000;
    localparam logic [3:0] c_bit_parity      = 4'd9;
    localparam logic [3:0] c_bit_stop        = 4'd10;

    // Odd parity over data+parity and a high stop bit make a frame good.
    function automatic logic frame_ok(scan_t data, logic parity, logic stop);
        return stop & ((^data) ^ parity);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_decoder_if.sv
`default_nettype none
// =============================================================================
// Module : ps2_decoder_if
// Brief  : Raw PS/2 lines in, decoded key state out.
// Rev    : 1.0  initial release
// =============================================================================
interface ps2_decoder_if;
    import ps2_decoder_pkg::*;

    logic  ps2_clk_async;
    logic  ps2_data_async;
    scan_t scan_code;
    scan_t ascii_code;
    logic  key_pressed;
    logic  key_released;

    modport master (
        input  ps2_clk_async, ps2_data_async,
        output scan_code, ascii_code, key_pressed, key_released
    );

    modport slave (
        output ps2_clk_async, ps2_data_async,
        input  scan_code, ascii_code, key_pressed, key_released
    );

endinterface
`default_nettype wire

// File: rtl/ps2_scan_to_ascii.sv
`default_nettype none
// =============================================================================
// Module : ps2_scan_to_ascii
// Brief  : Combinational Set-2 make code to ASCII table, unshifted/shifted.
// Rev    : 1.0  initial release
// =============================================================================
module ps2_scan_to_ascii
    import ps2_decoder_pkg::*;
(
    input  scan_t i_code,
    input  logic  i_shift,
    output scan_t o_ascii
);

    // Upper byte is the unshifted character, lower byte the shifted one.
    logic [15:0] w_pair;

    always_comb begin
        w_pair = 16'h0000;
        case (i_code)
            8'h1C: w_pair = "aA";   8'h32: w_pair = "bB";   8'h21: w_pair = "cC";
            8'h23: w_pair = "dD";   8'h24: w_pair = "eE";   8'h2B: w_pair = "fF";
            8'h34: w_pair = "gG";   8'h33: w_pair = "hH";   8'h43: w_pair = "iI";
            8'h3B: w_pair = "jJ";   8'h42: w_pair = "kK";   8'h4B: w_pair = "lL";
            8'h3A: w_pair = "mM";   8'h31: w_pair = "nN";   8'h44: w_pair = "oO";
            8'h4D: w_pair = "pP";   8'h15: w_pair = "qQ";   8'h2D: w_pair = "rR";
            8'h1B: w_pair = "sS";   8'h2C: w_pair = "tT";   8'h3C: w_pair = "uU";
            8'h2A: w_pair = "vV";   8'h1D: w_pair = "wW";   8'h22: w_pair = "xX";
            8'h35: w_pair = "yY";   8'h1A: w_pair = "zZ";
            8'h45: w_pair = "0)";   8'h16: w_pair = "1!";   8'h1E: w_pair = "2@";
            8'h26: w_pair = "3#";   8'h25: w_pair = "4$";   8'h2E: w_pair = "5%";
            8'h36: w_pair = "6^";   8'h3D: w_pair = "7&";   8'h3E: w_pair = "8*";
            8'h46: w_pair = "9(";
            8'h4E: w_pair = "-_";   8'h55: w_pair = "=+";   8'h54: w_pair = "[{";
            8'h5B: w_pair = "]}";   8'h5D: w_pair = {8'h5C, 8'h7C};
            8'h4C: w_pair = ";:";   8'h52: w_pair = {8'h27, 8'h22};
            8'h41: w_pair = ",<";   8'h49: w_pair = ".>";
            8'h4A: w_pair = "/?";   8'h0E: w_pair = "`~";
            8'h29: w_pair = {8'h20, 8'h20};
            8'h5A: w_pair = {8'h0D, 8'h0D};
            8'h66: w_pair = {8'h08, 8'h08};
            8'h0D: w_pair = {8'h09, 8'h09};
            8'h76: w_pair = {8'h1B, 8'h1B};
            default: w_pair = 16'h0000;
        endcase
    end

    assign o_ascii = i_shift ? w_pair[7:0] : w_pair[15:8];

endmodule
`default_nettype wire

// File: rtl/ps2_decoder.sv
`default_nettype none
// =============================================================================
// Module : ps2_decoder
// Brief  : PS/2 keyboard receiver: sync, deframe, make/break tracking, ASCII.
// Rev    : 1.0  initial release
// =============================================================================
module ps2_decoder
    import ps2_decoder_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = c_timeout_default
)
(
    input  logic          clk,
    input  logic          reset_n,
    ps2_decoder_if.master bus
);

    localparam int                c_to_w    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_to_w-1:0] c_to_last = c_to_w'(TIMEOUT_CYCLES - 1);
    localparam logic [c_to_w-1:0] c_to_one  = c_to_w'(1);

    logic [1:0]        r_rst_sync;
    logic              w_rst_n;
    logic [2:0]        r_clk_sync;
    logic [1:0]        r_data_sync;
    logic [3:0]        r_bit_cnt;
    scan_t             r_shreg;
    logic              r_parity;
    logic              r_byte_valid;
    logic [c_to_w-1:0] r_to_cnt;
    logic              r_brk;
    logic              r_ext;
    logic              r_shift;
    scan_t             r_scan;
    scan_t             r_ascii;
    logic              r_pressed;
    logic              r_released;
    scan_t             w_ascii;
    logic              w_fall;
    logic              w_bit;
    logic              w_timeout;

    // Assert asynchronously, release on a clock edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_rst_sync <= 2'b00;
        else          r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    assign w_fall    = r_clk_sync[2] & ~r_clk_sync[1];
    assign w_bit     = r_data_sync[1];
    assign w_timeout = ~w_fall & (r_bit_cnt != 4'd0) & (r_to_cnt == c_to_last);

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_clk_sync   <= 3'b111;
            r_data_sync  <= 2'b11;
            r_bit_cnt    <= 4'd0;
            r_shreg      <= '0;
            r_parity     <= 1'b0;
            r_byte_valid <= 1'b0;
            r_to_cnt     <= '0;
        end else begin
            r_clk_sync   <= {r_clk_sync[1:0], bus.ps2_clk_async};
            r_data_sync  <= {r_data_sync[0], bus.ps2_data_async};
            r_byte_valid <= 1'b0;
            if (w_fall) begin
                r_to_cnt <= '0;
                if (r_bit_cnt == 4'd0) begin
                    // A high start bit is line noise, not a frame.
                    if (!w_bit) r_bit_cnt <= 4'd1;
                end else if (r_bit_cnt == c_bit_parity) begin
                    r_parity  <= w_bit;
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                end else if (r_bit_cnt == c_bit_stop) begin
                    r_bit_cnt    <= 4'd0;
                    r_byte_valid <= frame_ok(r_shreg, r_parity, w_bit);
                end else begin
                    r_shreg   <= {w_bit, r_shreg[7:1]};
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                end
            end else if (w_timeout) begin
                r_bit_cnt <= 4'd0;
                r_to_cnt  <= '0;
            end else if (r_bit_cnt != 4'd0) begin
                r_to_cnt <= r_to_cnt + c_to_one;
            end else begin
                r_to_cnt <= '0;
            end
        end
    end

    // r_shreg holds the completed byte until the next frame starts shifting.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_brk      <= 1'b0;
            r_ext      <= 1'b0;
            r_shift    <= 1'b0;
            r_scan     <= '0;
            r_ascii    <= '0;
            r_pressed  <= 1'b0;
            r_released <= 1'b0;
        end else begin
            r_released <= 1'b0;
            if (r_byte_valid) begin
                if (r_shreg == c_code_ext) begin
                    r_ext <= 1'b1;
                end else if (r_shreg == c_code_brk) begin
                    r_brk <= 1'b1;
                end else begin
                    r_brk <= 1'b0;
                    r_ext <= 1'b0;
                    if (r_shreg == c_code_lshift || r_shreg == c_code_rshift) begin
                        r_shift <= ~r_brk;
                    end else if (!r_brk) begin
                        r_scan    <= r_shreg;
                        r_ascii   <= r_ext ? 8'h00 : w_ascii;
                        r_pressed <= 1'b1;
                    end else if (r_shreg == r_scan) begin
                        r_pressed  <= 1'b0;
                        r_released <= 1'b1;
                    end
                end
            end else if (w_timeout) begin
                r_brk <= 1'b0;
                r_ext <= 1'b0;
            end
        end
    end

    ps2_scan_to_ascii u_map (
        .i_code  (r_shreg),
        .i_shift (r_shift),
        .o_ascii (w_ascii)
    );

    assign bus.scan_code    = r_scan;
    assign bus.ascii_code   = r_ascii;
    assign bus.key_pressed  = r_pressed;
    assign bus.key_released = r_released;

endmodule
`default_nettype wire

// File: tb/tb_ps2_decoder.sv
`default_nettype none
// =============================================================================
// Module : tb_ps2_decoder
// Brief  : Directed and random PS/2 frames against a key-state reference model.
// Rev    : 1.0  initial release
// =============================================================================
module tb_ps2_decoder;
    import ps2_decoder_pkg::*;

    localparam int c_timeout = 300;
    localparam int c_half    = 8;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_fails  = 0;
    int   rel_cnt  = 0;

    logic [7:0] lut_lo [256];
    logic [7:0] lut_hi [256];
    logic [7:0] mapped_q [$];

    logic [7:0] m_scan, m_ascii;
    logic       m_pressed, m_brk, m_ext, m_shift;

    always #10 clk = ~clk;

    ps2_decoder_if bus ();

    ps2_decoder #(.TIMEOUT_CYCLES(c_timeout)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always @(posedge clk) if (bus.key_released === 1'b1) rel_cnt++;

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic add_map(input logic [7:0] code, input logic [7:0] lo, input logic [7:0] hi);
        lut_lo[code] = lo;
        lut_hi[code] = hi;
        mapped_q.push_back(code);
    endtask

    task automatic init_lut();
        logic [7:0] let_c [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                   8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                   8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
        logic [7:0] dig_c [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
        logic [7:0] pun_c [11] = '{8'h4E, 8'h55, 8'h54, 8'h5B, 8'h5D, 8'h4C, 8'h52, 8'h41, 8'h49, 8'h4A, 8'h0E};
        logic [7:0] pun_l [11] = '{8'h2D, 8'h3D, 8'h5B, 8'h5D, 8'h5C, 8'h3B, 8'h27, 8'h2C, 8'h2E, 8'h2F, 8'h60};
        logic [7:0] pun_h [11] = '{8'h5F, 8'h2B, 8'h7B, 8'h7D, 8'h7C, 8'h3A, 8'h22, 8'h3C, 8'h3E, 8'h3F, 8'h7E};
        logic [7:0] ctl_c [5]  = '{8'h29, 8'h5A, 8'h66, 8'h0D, 8'h76};
        logic [7:0] ctl_a [5]  = '{8'h20, 8'h0D, 8'h08, 8'h09, 8'h1B};
        string letters = "abcdefghijklmnopqrstuvwxyz";
        string dig_lo  = "0123456789";
        string dig_hi  = ")!@#$%^&*(";
        for (int i = 0; i < 256; i++) begin
            lut_lo[i] = 8'h00;
            lut_hi[i] = 8'h00;
        end
        for (int i = 0; i < 26; i++) add_map(let_c[i], letters[i], letters[i] - 8'h20);
        for (int i = 0; i < 10; i++) add_map(dig_c[i], dig_lo[i], dig_hi[i]);
        for (int i = 0; i < 11; i++) add_map(pun_c[i], pun_l[i], pun_h[i]);
        for (int i = 0; i < 5; i++)  add_map(ctl_c[i], ctl_a[i], ctl_a[i]);
    endtask

    task automatic model_reset();
        m_scan = 8'h00; m_ascii = 8'h00; m_pressed = 1'b0;
        m_brk = 1'b0; m_ext = 1'b0; m_shift = 1'b0;
    endtask

    // Returns the number of release pulses this byte should produce.
    function automatic int model_byte(input logic [7:0] b);
        int rel = 0;
        if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else begin
            if (b == 8'h12 || b == 8'h59) m_shift = !m_brk;
            else if (!m_brk) begin
                m_scan    = b;
                m_ascii   = m_ext ? 8'h00 : (m_shift ? lut_hi[b] : lut_lo[b]);
                m_pressed = 1'b1;
            end else if (b == m_scan) begin
                m_pressed = 1'b0;
                rel = 1;
            end
            m_brk = 1'b0;
            m_ext = 1'b0;
        end
        return rel;
    endfunction

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            bus.ps2_data_async = f[i];
            repeat (c_half / 2) @(negedge clk);
            bus.ps2_clk_async = 1'b0;
            repeat (c_half) @(negedge clk);
            bus.ps2_clk_async = 1'b1;
            repeat (c_half / 2) @(negedge clk);
        end
        bus.ps2_data_async = 1'b1;
    endtask

    task automatic check_outputs(input string tag, input int exp_rel, input int got_rel);
        check_val({tag, " scan_code"},    bus.scan_code,    m_scan);
        check_val({tag, " ascii_code"},   bus.ascii_code,   m_ascii);
        check_val({tag, " key_pressed"},  bus.key_pressed,  m_pressed);
        check_val({tag, " release_clks"}, got_rel,          exp_rel);
        check_val({tag, " key_released"}, bus.key_released, 1'b0);
    endtask

    task automatic frame_check(input string tag, input logic [7:0] b, input bit bad);
        int rel0;
        int exp_rel;
        rel0 = rel_cnt;
        send_frame(b, bad, 11);
        repeat (30) @(negedge clk);
        exp_rel = bad ? 0 : model_byte(b);
        check_outputs($sformatf("%s[%02h]", tag, b), exp_rel, rel_cnt - rel0);
    endtask

    task automatic timeout_frame(input string tag, input int nbits);
        send_frame(8'h00, 1'b0, nbits);
        repeat (c_timeout + 50) @(negedge clk);
        m_brk = 1'b0;
        m_ext = 1'b0;
        check_val({tag, " scan_code"},   bus.scan_code,   m_scan);
        check_val({tag, " key_pressed"}, bus.key_pressed, m_pressed);
    endtask

    initial begin
        int         sel;
        logic [7:0] b;
        init_lut();
        model_reset();
        bus.ps2_clk_async  = 1'b1;
        bus.ps2_data_async = 1'b1;
        repeat (5) @(negedge clk);
        check_val("reset scan_code",    bus.scan_code,    8'h00);
        check_val("reset ascii_code",   bus.ascii_code,   8'h00);
        check_val("reset key_pressed",  bus.key_pressed,  1'b0);
        check_val("reset key_released", bus.key_released, 1'b0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        frame_check("make", 8'h1C, 1'b0);
        check_val("make a ascii", bus.ascii_code, 8'h61);
        frame_check("brk", 8'hF0, 1'b0);
        frame_check("brk", 8'h1C, 1'b0);
        check_val("break a pressed", bus.key_pressed, 1'b0);
        check_val("break a ascii", bus.ascii_code, 8'h61);
        frame_check("shift", 8'h12, 1'b0);
        frame_check("shift", 8'h1C, 1'b0);
        check_val("shift A ascii", bus.ascii_code, 8'h41);
        frame_check("shift", 8'h16, 1'b0);
        check_val("shift ! ascii", bus.ascii_code, 8'h21);
        frame_check("unshift", 8'hF0, 1'b0);
        frame_check("unshift", 8'h12, 1'b0);
        frame_check("unshift", 8'h1C, 1'b0);
        check_val("unshift a ascii", bus.ascii_code, 8'h61);
        frame_check("badpar", 8'h1C, 1'b1);
        frame_check("good", 8'h32, 1'b0);
        check_val("after badpar ascii", bus.ascii_code, 8'h62);
        timeout_frame("timeout", 6);
        frame_check("post_to", 8'h29, 1'b0);
        check_val("post timeout ascii", bus.ascii_code, 8'h20);
        frame_check("ext", 8'hE0, 1'b0);
        frame_check("ext", 8'h75, 1'b0);
        check_val("ext ascii", bus.ascii_code, 8'h00);
        check_val("ext pressed", bus.key_pressed, 1'b1);

        send_frame(8'h55, 1'b0, 5);
        @(negedge clk);
        #3 reset_n = 1'b0;
        #1;
        check_val("midreset scan_code",    bus.scan_code,    8'h00);
        check_val("midreset ascii_code",   bus.ascii_code,   8'h00);
        check_val("midreset key_pressed",  bus.key_pressed,  1'b0);
        check_val("midreset key_released", bus.key_released, 1'b0);
        model_reset();
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        frame_check("recover", 8'h1C, 1'b0);

        for (int it = 0; it < 60; it++) begin
            sel = $urandom_range(0, 9);
            b   = mapped_q[$urandom_range(0, mapped_q.size() - 1)];
            case (sel)
                0, 1, 2: frame_check("rnd_make", b, 1'b0);
                3: begin
                    frame_check("rnd_brk", 8'hF0, 1'b0);
                    frame_check("rnd_brk", m_scan, 1'b0);
                end
                4: begin
                    if ($urandom_range(0, 1) == 1) frame_check("rnd_shf", 8'hF0, 1'b0);
                    frame_check("rnd_shf", ($urandom_range(0, 1) == 1) ? 8'h12 : 8'h59, 1'b0);
                end
                5: begin
                    frame_check("rnd_ext", 8'hE0, 1'b0);
                    frame_check("rnd_ext", b, 1'b0);
                end
                6: frame_check("rnd_bad", b, 1'b1);
                7: frame_check("rnd_any", 8'($urandom_range(0, 255)), 1'b0);
                8: begin
                    frame_check("rnd_obrk", 8'hF0, 1'b0);
                    frame_check("rnd_obrk", b, 1'b0);
                end
                default: timeout_frame("rnd_to", $urandom_range(1, 10));
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
